adc_capture_ctrl: RTL and testbench

//  Sits between the RFSoC Data Converter ADC AXIS output and the capture FIFO.

---
 rtl/adc_capture_ctrl_if.sv | 24 ++
 rtl/adc_capture_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_ctrl_if.sv
// AXI4-Stream beat bundle for the ADC input and the capture FIFO output.
// master drives data/valid/last, slave returns ready.
interface adc_capture_ctrl_if #(
    parameter int DATA_W = 256
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/adc_capture_ctrl.sv
// Triggered, delayed, edge-masked ADC beat capture with serial gpio config.
// Define ADC_CAPTURE_DECIM_EN to add the beat decimation register.
module adc_capture_ctrl #(
    parameter int DATA_W        = 256,
    parameter int CNT_W         = 32,
    parameter int SDATA_BIT     = 0,
    parameter int MASK_CLK_BIT  = 1,
    parameter int COUNT_CLK_BIT = 2,
    parameter int DELAY_CLK_BIT = 3,
    parameter int DECIM_CLK_BIT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    adc_capture_ctrl_if.slave         s_axis,
    adc_capture_ctrl_if.master        m_axis,
    input  logic [15:0]               gpio_ctrl,
    input  logic                      select_in,
    input  logic                      trigger_in,
    output logic                      busy,
    output logic                      overflow
);

`ifdef ADC_CAPTURE_DECIM_EN
    localparam int NCK = 4;
`else
    localparam int NCK = 3;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_CAPTURE,
        S_DONE
    } state_e;

    // bit 0 is serial data, bits 1..NCK are the per-register shift clocks
    logic [NCK:0] cfg_raw;
    logic [NCK:0] sync1_q;
    logic [NCK:0] sync2_q;
    logic [NCK:1] prev_q;
    logic [NCK:1] shift_en;
    logic         sdata;

    assign cfg_raw[0] = gpio_ctrl[SDATA_BIT];
    assign cfg_raw[1] = gpio_ctrl[MASK_CLK_BIT];
    assign cfg_raw[2] = gpio_ctrl[COUNT_CLK_BIT];
    assign cfg_raw[3] = gpio_ctrl[DELAY_CLK_BIT];
`ifdef ADC_CAPTURE_DECIM_EN
    assign cfg_raw[4] = gpio_ctrl[DECIM_CLK_BIT];
`endif

    assign shift_en = sync2_q[NCK:1] & ~prev_q & {NCK{select_in}};
    assign sdata    = sync2_q[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= cfg_raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q[NCK:1];
        end
    end

    logic [DATA_W-1:0] mask_reg_q,  mask_reg_d;
    logic [CNT_W-1:0]  count_reg_q, count_reg_d;
    logic [CNT_W-1:0]  delay_reg_q, delay_reg_d;
`ifdef ADC_CAPTURE_DECIM_EN
    logic [CNT_W-1:0]  decim_reg_q, decim_reg_d;
`endif

    always_comb begin
        mask_reg_d  = mask_reg_q;
        count_reg_d = count_reg_q;
        delay_reg_d = delay_reg_q;
        if (shift_en[1])
            mask_reg_d = {mask_reg_q[DATA_W-2:0], sdata};
        if (shift_en[2])
            count_reg_d = {count_reg_q[CNT_W-2:0], sdata};
        if (shift_en[3])
            delay_reg_d = {delay_reg_q[CNT_W-2:0], sdata};
    end

`ifdef ADC_CAPTURE_DECIM_EN
    always_comb begin
        decim_reg_d = decim_reg_q;
        if (shift_en[4])
            decim_reg_d = {decim_reg_q[CNT_W-2:0], sdata};
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_reg_q  <= '0;
            count_reg_q <= '0;
            delay_reg_q <= '0;
`ifdef ADC_CAPTURE_DECIM_EN
            decim_reg_q <= '0;
`endif
        end else begin
            mask_reg_q  <= mask_reg_d;
            count_reg_q <= count_reg_d;
            delay_reg_q <= delay_reg_d;
`ifdef ADC_CAPTURE_DECIM_EN
            decim_reg_q <= decim_reg_d;
`endif
        end
    end

    state_e            state_q;
    logic              armed_q;
    logic [DATA_W-1:0] mask_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  dly_q;
    logic              first_q;
    logic [DATA_W-1:0] m_tdata_q;
    logic              m_tvalid_q;
    logic              m_tlast_q;
    logic              busy_q;
    logic              ovf_q;
    logic              take;
    logic [DATA_W-1:0] beat_data;
`ifdef ADC_CAPTURE_DECIM_EN
    logic [CNT_W-1:0]  dec_q;
    logic [CNT_W-1:0]  dlat_q;

    assign take = (state_q == S_CAPTURE) && s_axis.tvalid && (dec_q == '0);
`else
    assign take = (state_q == S_CAPTURE) && s_axis.tvalid;
`endif

    // a single-beat capture is both first and last and takes the first-beat mask
    always_comb begin
        beat_data = s_axis.tdata;
        if (first_q)
            beat_data = s_axis.tdata & mask_q;
        else if (cnt_q == '0)
            beat_data = s_axis.tdata & ~mask_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            armed_q    <= 1'b0;
            mask_q     <= '0;
            cnt_q      <= '0;
            dly_q      <= '0;
            first_q    <= 1'b0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef ADC_CAPTURE_DECIM_EN
            dec_q      <= '0;
            dlat_q     <= '0;
`endif
        end else begin
            armed_q    <= 1'b1;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            // an unaccepted output beat is lost; the next beat overwrites it
            if (m_tvalid_q && !m_axis.tready)
                ovf_q <= 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (trigger_in && armed_q) begin
                        mask_q  <= mask_reg_q;
                        cnt_q   <= count_reg_q;
                        dly_q   <= delay_reg_q;
                        first_q <= 1'b1;
                        busy_q  <= 1'b1;
                        ovf_q   <= 1'b0;
`ifdef ADC_CAPTURE_DECIM_EN
                        dec_q   <= '0;
                        dlat_q  <= decim_reg_q;
`endif
                        state_q <= (delay_reg_q != '0) ? S_DELAY : S_CAPTURE;
                    end
                end
                S_DELAY: begin
                    dly_q <= dly_q - CNT_W'(1);
                    if (dly_q == CNT_W'(1))
                        state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
`ifdef ADC_CAPTURE_DECIM_EN
                    if (s_axis.tvalid)
                        dec_q <= (dec_q == '0) ? dlat_q : dec_q - CNT_W'(1);
`endif
                    if (take) begin
                        m_tdata_q  <= beat_data;
                        m_tvalid_q <= 1'b1;
                        m_tlast_q  <= (cnt_q == '0);
                        first_q    <= 1'b0;
                        if (cnt_q == '0)
                            state_q <= S_DONE;
                        else
                            cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign s_axis.tready = 1'b1;
    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tvalid = m_tvalid_q;
    assign m_axis.tlast  = m_tlast_q;
    assign busy          = busy_q;
    assign overflow      = ovf_q;

    logic unused_ok;
`ifdef ADC_CAPTURE_DECIM_EN
    assign unused_ok = ^{s_axis.tlast, gpio_ctrl};
`else
    assign unused_ok = ^{s_axis.tlast, gpio_ctrl, gpio_ctrl[DECIM_CLK_BIT]};
`endif

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: config shifting, delay, masking,
// backpressure, retrigger, reset abort and (with the macro) decimation.
module tb_adc_capture_ctrl;

    localparam int SDATA_BIT     = 0;
    localparam int MASK_CLK_BIT  = 1;
    localparam int COUNT_CLK_BIT = 2;
    localparam int DELAY_CLK_BIT = 3;
    localparam int DECIM_CLK_BIT = 4;
    localparam logic [255:0] MASK = 256'hFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] gpio_ctrl = '0;
    logic        select_in = 1'b1;
    logic        trigger_in = 1'b0;
    logic        busy;
    logic        overflow;

    adc_capture_ctrl_if #(.DATA_W(256)) s_axis ();
    adc_capture_ctrl_if #(.DATA_W(256)) m_axis ();

    adc_capture_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .s_axis     (s_axis),
        .m_axis     (m_axis),
        .gpio_ctrl  (gpio_ctrl),
        .select_in  (select_in),
        .trigger_in (trigger_in),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0 = 0;
    int first_cyc = -1;
    int busy_cnt = 0;
    logic [255:0] beats[$];
    logic         lasts[$];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (m_axis.tvalid && m_axis.tready) begin
            if (beats.size() == 0) first_cyc = cyc;
            beats.push_back(m_axis.tdata);
            lasts.push_back(m_axis.tlast);
        end
    end

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] data_of(input int n);
        logic [15:0] s;
        s = 16'hA500 | 16'(n);
        return {16{s}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        beats.delete();
        lasts.delete();
        busy_cnt = 0;
        first_cyc = -1;
    endtask

    task automatic shift_in(input int ck, input logic [255:0] val,
                            input int width);
        for (int b = width - 1; b >= 0; b--) begin
            gpio_ctrl[SDATA_BIT] = val[b];
            step();
            gpio_ctrl[ck] = 1'b1;
            repeat (3) step();
            gpio_ctrl[ck] = 1'b0;
            repeat (3) step();
        end
    endtask

    task automatic capture(input int ncyc, input int stall_a,
                           input int stall_b, input int retrig);
        clear_mon();
        t0 = cyc;
        trigger_in = 1'b1;
        s_axis.tvalid = 1'b1;
        s_axis.tdata = data_of(0);
        step();
        trigger_in = 1'b0;
        for (int i = 1; i <= ncyc; i++) begin
            s_axis.tdata = data_of(i);
            m_axis.tready = !(i == stall_a || i == stall_b);
            trigger_in = (i == retrig);
            step();
        end
        trigger_in = 1'b0;
        m_axis.tready = 1'b1;
    endtask

    initial begin
        s_axis.tdata = '0;
        s_axis.tvalid = 1'b0;
        s_axis.tlast = 1'b0;
        m_axis.tready = 1'b1;
        repeat (3) step();
        check("rst_tready", 256'(s_axis.tready), 256'(1));
        check("rst_tvalid", 256'(m_axis.tvalid), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_ovf", 256'(overflow), 256'(0));
        rst = 1'b1;
        repeat (2) step();

        // basic 4-beat capture, no delay
        shift_in(MASK_CLK_BIT, 256'hFF, 8);
        shift_in(COUNT_CLK_BIT, 256'd3, 32);
        shift_in(DELAY_CLK_BIT, 256'd0, 32);
        capture(12, -1, -1, -1);
        check("t1_nbeats", 256'(beats.size()), 256'(4));
        check("t1_b0", beats[0], data_of(1) & MASK);
        check("t1_b1", beats[1], data_of(2));
        check("t1_b2", beats[2], data_of(3));
        check("t1_b3", beats[3], data_of(4) & ~MASK);
        check("t1_last0", 256'(lasts[0]), 256'(0));
        check("t1_last3", 256'(lasts[3]), 256'(1));
        check("t1_busy", 256'(busy_cnt), 256'(6));

        // delay 5, single beat
        shift_in(COUNT_CLK_BIT, 256'd0, 32);
        shift_in(DELAY_CLK_BIT, 256'd5, 32);
        capture(12, -1, -1, -1);
        check("t2_nbeats", 256'(beats.size()), 256'(1));
        check("t2_cyc", 256'(first_cyc), 256'(t0 + 7));
        check("t2_data", beats[0], data_of(6) & MASK);
        check("t2_last", 256'(lasts[0]), 256'(1));

        // count 0, no delay
        shift_in(DELAY_CLK_BIT, 256'd0, 32);
        capture(8, -1, -1, -1);
        check("t3_nbeats", 256'(beats.size()), 256'(1));
        check("t3_data", beats[0], data_of(1) & MASK);
        check("t3_last", 256'(lasts[0]), 256'(1));
        check("t3_ovf", 256'(overflow), 256'(0));

        // backpressure drops two beats
        shift_in(COUNT_CLK_BIT, 256'd7, 32);
        capture(14, 5, 6, -1);
        check("t4_nbeats", 256'(beats.size()), 256'(6));
        check("t4_b2", beats[2], data_of(3));
        check("t4_b3", beats[3], data_of(6));
        check("t4_b5", beats[5], data_of(8) & ~MASK);
        check("t4_last5", 256'(lasts[5]), 256'(1));
        check("t4_last4", 256'(lasts[4]), 256'(0));
        check("t4_ovf", 256'(overflow), 256'(1));
        capture(14, -1, -1, -1);
        check("t4_ovf_clr", 256'(overflow), 256'(0));
        check("t4_nbeats2", 256'(beats.size()), 256'(8));

        // retrigger during capture is ignored
        shift_in(COUNT_CLK_BIT, 256'd3, 32);
        capture(14, -1, -1, 2);
        check("t5_nbeats", 256'(beats.size()), 256'(4));
        check("t5_b3", beats[3], data_of(4) & ~MASK);
        check("t5_busy", 256'(busy_cnt), 256'(6));

`ifdef ADC_CAPTURE_DECIM_EN
        shift_in(DECIM_CLK_BIT, 256'd1, 32);
        capture(14, -1, -1, -1);
        check("dec_nbeats", 256'(beats.size()), 256'(4));
        check("dec_b0", beats[0], data_of(1) & MASK);
        check("dec_b1", beats[1], data_of(3));
        check("dec_b2", beats[2], data_of(5));
        check("dec_b3", beats[3], data_of(7) & ~MASK);
`endif

        // reset mid-capture
        clear_mon();
        trigger_in = 1'b1;
        s_axis.tdata = data_of(0);
        step();
        trigger_in = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            s_axis.tdata = data_of(i);
            step();
        end
        check("t5_midvalid", 256'(m_axis.tvalid), 256'(1));
        #2;
        rst = 1'b0;
        #1;
        check("abort_tvalid", 256'(m_axis.tvalid), 256'(0));
        check("abort_tlast", 256'(m_axis.tlast), 256'(0));
        check("abort_tdata", m_axis.tdata, 256'(0));
        check("abort_busy", 256'(busy), 256'(0));
        check("abort_tready", 256'(s_axis.tready), 256'(1));
        repeat (2) step();
        clear_mon();
        rst = 1'b1;
        trigger_in = 1'b1;
        step();
        trigger_in = 1'b0;
        repeat (6) step();
        check("rel_trig_busy", 256'(busy_cnt), 256'(0));
        check("rel_trig_beats", 256'(beats.size()), 256'(0));

        // shifts with select_in low leave the cleared registers alone
        select_in = 1'b0;
        shift_in(COUNT_CLK_BIT, 256'hFFFF_FFFF, 32);
        shift_in(MASK_CLK_BIT, 256'hFF, 8);
        shift_in(DELAY_CLK_BIT, 256'd3, 32);
        select_in = 1'b1;
        capture(10, -1, -1, -1);
        check("sel_nbeats", 256'(beats.size()), 256'(1));
        check("sel_data", beats[0], 256'(0));
        check("sel_last", 256'(lasts[0]), 256'(1));
        check("sel_cyc", 256'(first_cyc), 256'(t0 + 2));

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
